gray_tracker: RTL
=================

// Module: gray_tracker
// PURPOSE
//   Downstream consumer of the 3-bit Gray-code counter. Samples its Output/Overflow pair every
//   clock, decodes the code to binary, and pulses once per legal forward step. It counts full
//   revolutions (100->000) and latches a sticky fault on any illegal transition. It feeds
//   control/debug logic that needs a binary count plus a trusted sequence-integrity flag.
// PARAMETERS
//   WRAP_W   8   width of revolution counter Wraps; saturates at 2^WRAP_W-1
// PORTS
//   Clk         in   1        single clock, all state updates on posedge
//   Reset       in   1        synchronous, active-high; highest priority
//   Clear       in   1        synchronous fault clear; second priority
//   Gray        in   3        Gray code from upstream counter Output
//   OvfIn       in   1        upstream sticky Overflow flag
//   Bin         out  3        binary value of last accepted Gray code
//   Step        out  1        1-cycle pulse: legal forward step accepted
//   WrapPulse   out  1        1-cycle pulse: legal 100->000 step accepted
//   Wraps       out  WRAP_W   count of accepted revolutions, saturating
//   Err         out  1        sticky fault flag
// BEHAVIOUR
//   Reset (sync, active-high): state=SYNC, prev=000, prevOvf=0, Bin=0, Step=0, WrapPulse=0,
//     Wraps=0, Err=0. Reset overrides Clear and all other inputs in the same cycle.
//   All outputs registered; decision on Gray/OvfIn at edge N is visible after edge N.
//   Decode: b2=g2; b1=g2^g1; b0=g2^g1^g0. Legal forward successor of g: g2b^-1(g2b(g)+1 mod 8).
//   States:
//     SYNC : capture prev<=Gray, prevOvf<=OvfIn, Bin<=decode(Gray); Step=0; -> TRACK.
//     TRACK: evaluate {Gray,OvfIn} against {prev,prevOvf}:
//       Gray==prev, OvfIn==prevOvf          -> hold; Step=0.
//       Gray==succ(prev), prev!=100, OvfIn==prevOvf
//                                           -> accept; Bin<=decode(Gray); Step=1.
//       prev==100, Gray==000, OvfIn==1      -> accept wrap; Bin<=0; Step=1; WrapPulse=1;
//                                              Wraps<=Wraps+1 unless already all-ones.
//       anything else (multi-bit change, backward step, OvfIn rising without 100->000,
//       OvfIn falling, 100->000 with OvfIn==0) -> Err<=1; -> FAULT. Bin not updated.
//     FAULT: Bin and Wraps frozen; Step=WrapPulse=0; Err=1; inputs ignored.
//       Clear=1 -> Err<=0; -> SYNC (Wraps retained).
//   Clear in SYNC/TRACK: no effect; TRACK still evaluates normally.
//   prev/prevOvf update on every accepted or hold cycle in TRACK; never on a fault.
//   Step and WrapPulse high for exactly one cycle per accepted transition; deasserted
//     otherwise, including the cycle after entering FAULT.
//   Wraps saturation: at all-ones a legal wrap still pulses WrapPulse; Wraps is unchanged.
//   Gray held constant indefinitely (upstream En low): no pulses, no fault.
// TESTING
//   1 Reset, then Gray walks 000,001,011,010,110,111,101,100 one per cycle, OvfIn=0 ->
//     Bin 0..7 one cycle behind each code, Step=1 seven times, Err=0.
//   2 From 100, Gray=000 with OvfIn 0->1 same cycle -> WrapPulse=1, Wraps=1, Bin=0; a second
//     revolution with OvfIn held 1 -> Wraps=2.
//   3 In TRACK at 011, Gray jumps to 110 -> Err=1 next cycle, Bin stays 2; further legal
//     codes ignored; Clear=1 -> Err=0, next cycle SYNC resamples Gray, then tracking resumes.
//   4 Gray holds 010 for 20 cycles -> Step=0 throughout, Err=0; backward step 010->011 -> Err=1.
//   5 WRAP_W=2: drive 4 legal revolutions -> Wraps 1,2,3,3 and WrapPulse on each.
//   6 Reset and Clear both high while in FAULT with Wraps=5 -> Wraps=0, Err=0, state SYNC.

Source files
------------

// File: rtl/gray_tracker.sv
// gray_tracker: downstream monitor for a 3-bit Gray-code counter.
//
// Each clock it samples the upstream Gray/OvfIn pair. It decodes the code to binary and
// pulses Step for every legal forward step. It also counts full revolutions (100 -> 000)
// and latches a sticky fault on any illegal transition.
//
// Ports:
//   Clk        in   1       clock, all state on posedge
//   Reset      in   1       synchronous, active-high, highest priority
//   Clear      in   1       synchronous fault clear (only acts in the fault state)
//   Gray       in   3       Gray code from the upstream counter
//   OvfIn      in   1       upstream sticky overflow flag
//   Bin        out  3       binary value of the last accepted Gray code
//   Step       out  1       one-cycle pulse per accepted forward step (wrap included)
//   WrapPulse  out  1       one-cycle pulse per accepted 100 -> 000 step
//   Wraps      out  WRAP_W  saturating revolution count
//   Err        out  1       sticky fault flag
//
// Every output is registered. A decision on the inputs sampled at edge N is visible
// after edge N.
module gray_tracker #(
  parameter int unsigned WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic [2:0]        Gray,
  input  logic              OvfIn,
  output logic [2:0]        Bin,
  output logic              Step,
  output logic              WrapPulse,
  output logic [WRAP_W-1:0] Wraps,
  output logic              Err
);

  typedef enum logic [1:0] {
    StSync  = 2'd0,
    StTrack = 2'd1,
    StFault = 2'd2
  } state_e;

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = g[2] ^ g[1] ^ g[0];
    return b;
  endfunction

  function automatic logic [2:0] bin2gray(input logic [2:0] b);
    return b ^ {1'b0, b[2:1]};
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        prev_q, prev_d;         // last accepted Gray code
  logic              prev_ovf_q, prev_ovf_d; // OvfIn seen alongside prev_q
  logic [2:0]        bin_q, bin_d;
  logic              step_q, step_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic              err_q, err_d;

  // Transition classification against the last accepted sample.
  logic [2:0] gray_bin;
  logic [2:0] prev_succ_bin;
  logic [2:0] prev_succ_gray;
  logic       prev_is_top;
  logic       is_hold;
  logic       is_fwd;
  logic       is_wrap;

  always_comb begin
    gray_bin       = gray2bin(Gray);
    prev_succ_bin  = gray2bin(prev_q) + 3'd1;
    prev_succ_gray = bin2gray(prev_succ_bin);
    prev_is_top    = (prev_q == 3'b100);
    is_hold        = (Gray == prev_q) && (OvfIn == prev_ovf_q);
    // The 100 -> 000 step is only legal as a wrap, which needs OvfIn set.
    is_fwd         = !prev_is_top && (Gray == prev_succ_gray) && (OvfIn == prev_ovf_q);
    is_wrap        = prev_is_top && (Gray == 3'b000) && OvfIn;
  end

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_ovf_d   = prev_ovf_q;
    bin_d        = bin_q;
    step_d       = 1'b0;
    wrap_pulse_d = 1'b0;
    wraps_d      = wraps_q;
    err_d        = err_q;

    unique case (state_q)
      StSync: begin
        // Resynchronise to whatever the counter currently shows. No pulse is given.
        prev_d     = Gray;
        prev_ovf_d = OvfIn;
        bin_d      = gray_bin;
        state_d    = StTrack;
      end

      StTrack: begin
        if (is_hold) begin
          prev_d     = Gray;
          prev_ovf_d = OvfIn;
        end else if (is_fwd) begin
          prev_d     = Gray;
          prev_ovf_d = OvfIn;
          bin_d      = gray_bin;
          step_d     = 1'b1;
        end else if (is_wrap) begin
          prev_d       = Gray;
          prev_ovf_d   = OvfIn;
          bin_d        = 3'd0;
          step_d       = 1'b1;
          wrap_pulse_d = 1'b1;
          if (!(&wraps_q)) begin
            wraps_d = wraps_q + 1'b1;
          end
        end else begin
          // prev/prev_ovf keep the last trusted sample. Bin is frozen.
          err_d   = 1'b1;
          state_d = StFault;
        end
      end

      StFault: begin
        err_d = 1'b1;
        if (Clear) begin
          err_d   = 1'b0;
          state_d = StSync;
        end
      end

      default: begin
        // Unreachable encoding: resynchronise rather than hang.
        state_d = StSync;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StSync;
      prev_q       <= 3'b000;
      prev_ovf_q   <= 1'b0;
      bin_q        <= 3'd0;
      step_q       <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wraps_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_ovf_q   <= prev_ovf_d;
      bin_q        <= bin_d;
      step_q       <= step_d;
      wrap_pulse_q <= wrap_pulse_d;
      wraps_q      <= wraps_d;
      err_q        <= err_d;
    end
  end

  assign Bin       = bin_q;
  assign Step      = step_q;
  assign WrapPulse = wrap_pulse_q;
  assign Wraps     = wraps_q;
  assign Err       = err_q;

endmodule
